// File: rtl/hazard_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline hazard controller. It sits beside the datapath and drives the
// stall/flush controls of the PC and of every pipeline register up to MEM/WB.
//
// It handles four hazard sources, in this priority order:
//   - D-cache miss: freezes the whole pipe and bubbles MEM/WB.
//   - EX redirect: flushes the fetch registers and ID/EX.
//   - Load-use: inserts LOAD_LAT bubbles into ID/EX while holding fetch.
//   - I-cache miss: holds PC and the early fetch registers, and bubbles IF/ID.
// A redirect that resolves during an I-miss is remembered in a pending flag,
// so the wrong-path line that eventually returns is still discarded.
//
// Parameters:
//   RA_W       register-file address width
//   IF_STAGES  fetch registers between PC and EX (>= 2); the last one is IF/ID
//   LOAD_LAT   load-use bubbles per hazard (1..7)
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   memread_ex, rf_we_ex      EX is a load / EX writes the RF
//   rf_wa_ex                  EX destination register
//   rf_ra{0,1}_id, rf_re{0,1}_id  ID source registers and their read enables
//   npc_sel_ex                EX redirect (taken branch/jump)
//   inst_sram_miss            I-cache miss this cycle
//   data_sram_miss            D-cache miss (MEM stage) this cycle
//   stall_pc                  hold PC
//   stall_if / flush_if       per-fetch-register hold / bubble
//   flush_id_ex, stall_id_ex, stall_ex_mem, flush_mem_wb
//
// Optional build macro HAZARD_PERF_EN adds 32-bit wrapping counters:
//   perf_lu_cyc    cycles with load-use stalling active
//   perf_dmiss_cyc cycles with data_sram_miss
//   perf_imiss_cyc cycles with inst_sram_miss
//   perf_redir     npc_sel_ex pulses (rising edges)
//
// All control outputs are combinational from the inputs and current state.
// ----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int unsigned RA_W      = 5,
    parameter int unsigned IF_STAGES = 2,
    parameter int unsigned LOAD_LAT  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 memread_ex,
    input  logic                 rf_we_ex,
    input  logic [RA_W-1:0]      rf_wa_ex,
    input  logic [RA_W-1:0]      rf_ra0_id,
    input  logic [RA_W-1:0]      rf_ra1_id,
    input  logic                 rf_re0_id,
    input  logic                 rf_re1_id,
    input  logic                 npc_sel_ex,
    input  logic                 inst_sram_miss,
    input  logic                 data_sram_miss,
    output logic                 stall_pc,
    output logic [IF_STAGES-1:0] stall_if,
    output logic [IF_STAGES-1:0] flush_if,
    output logic                 flush_id_ex,
    output logic                 stall_id_ex,
    output logic                 stall_ex_mem,
    output logic                 flush_mem_wb
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]          perf_lu_cyc,
    output logic [31:0]          perf_dmiss_cyc,
    output logic [31:0]          perf_imiss_cyc,
    output logic [31:0]          perf_redir
`endif
);

    typedef enum logic [0:0] {
        StIdle,
        StLuWait
    } state_e;

    // Remaining bubbles after the first one of a load-use hazard.
    localparam logic [2:0] LuInit = 3'(LOAD_LAT - 1);

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       redir_pend_q, redir_pend_d;

    logic lu;
    logic lu_busy;
    logic lu_active;

    assign lu = memread_ex & rf_we_ex & (rf_wa_ex != '0) &
                ((rf_re0_id & (rf_wa_ex == rf_ra0_id)) |
                 (rf_re1_id & (rf_wa_ex == rf_ra1_id)));

    assign lu_busy = (state_q == StLuWait);

    // Load-use stalling is in effect this cycle (nothing of higher priority).
    assign lu_active = ~rst & ~data_sram_miss & ~npc_sel_ex & (lu | lu_busy);

    always_comb begin
        stall_pc     = 1'b0;
        stall_if     = '0;
        flush_if     = '0;
        flush_id_ex  = 1'b0;
        stall_id_ex  = 1'b0;
        stall_ex_mem = 1'b0;
        flush_mem_wb = 1'b0;
        state_d      = state_q;
        cnt_d        = cnt_q;
        redir_pend_d = redir_pend_q;

        if (rst) begin
            // Outputs stay quiet; state is cleared by the register block.
        end else if (data_sram_miss) begin
            // Freeze everything; MEM/WB gets a bubble. State is held.
            stall_pc     = 1'b1;
            stall_if     = '1;
            stall_id_ex  = 1'b1;
            stall_ex_mem = 1'b1;
            flush_mem_wb = 1'b1;
        end else begin
            if (npc_sel_ex) begin
                flush_if    = '1;
                flush_id_ex = 1'b1;
                state_d     = StIdle;
                cnt_d       = 3'd0;
            end else if (lu || lu_busy) begin
                stall_pc    = 1'b1;
                stall_if    = '1;
                flush_id_ex = 1'b1;
                if (lu_busy) begin
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        state_d = StIdle;
                    end
                end else if (LOAD_LAT > 1) begin
                    state_d = StLuWait;
                    cnt_d   = LuInit;
                end
            end

            if (inst_sram_miss) begin
                stall_pc                   = 1'b1;
                stall_if[IF_STAGES-2:0]    = '1;
                // IF/ID gets a bubble unless something already holds it.
                flush_if[IF_STAGES-1]      = flush_if[IF_STAGES-1] | ~stall_if[IF_STAGES-1];
            end

            // A redirect seen during the miss: the line in flight is wrong-path,
            // both while it is outstanding and in the cycle it lands.
            if (redir_pend_q) begin
                flush_if[0] = 1'b1;
            end

            redir_pend_d = inst_sram_miss & (npc_sel_ex | redir_pend_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= 3'd0;
            redir_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            redir_pend_q <= redir_pend_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic        npc_q;
    logic [31:0] perf_lu_q, perf_dmiss_q, perf_imiss_q, perf_redir_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            npc_q        <= 1'b0;
            perf_lu_q    <= 32'd0;
            perf_dmiss_q <= 32'd0;
            perf_imiss_q <= 32'd0;
            perf_redir_q <= 32'd0;
        end else begin
            npc_q <= npc_sel_ex;
            if (lu_active)              perf_lu_q    <= perf_lu_q + 32'd1;
            if (data_sram_miss)         perf_dmiss_q <= perf_dmiss_q + 32'd1;
            if (inst_sram_miss)         perf_imiss_q <= perf_imiss_q + 32'd1;
            if (npc_sel_ex && !npc_q)   perf_redir_q <= perf_redir_q + 32'd1;
        end
    end

    assign perf_lu_cyc    = perf_lu_q;
    assign perf_dmiss_cyc = perf_dmiss_q;
    assign perf_imiss_cyc = perf_imiss_q;
    assign perf_redir     = perf_redir_q;
`else
    logic unused_lu_active;
    assign unused_lu_active = lu_active;
`endif

endmodule
